// File: rtl/spi_slave_xfer.sv
`timescale 1ns/1ps
// Full-duplex SPI slave supporting all four CPOL/CPHA modes and a configurable word width.
// SPI pins are synchronised into clk; words stream back-to-back within one chip-select frame.
module spi_slave_xfer #(
  parameter int width = 24,
  parameter bit CPOL  = 1'b0,
  parameter bit CPHA  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             nCS,
  input  logic             SCK,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_oe,
  input  logic [width-1:0] tx_data,
  output logic             tx_ack,
  output logic [width-1:0] rx_data,
  output logic             rx_valid,
  output logic             new_transfer,
  output logic             transfer_done,
  output logic             frame_error,
  output logic             busy
);

  localparam int CW = (width > 2) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(width - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t           r_state, w_state_n;
  logic [2:0]       r_ncs_sync, r_sck_sync;
  logic [1:0]       r_mosi_sync;
  logic [CW-1:0]    r_bitcnt, w_bitcnt_n;
  logic [width-1:0] r_txshift, w_txshift_n;
  logic [width-1:0] r_rxshift, w_rxshift_n;
  logic [width-1:0] r_rx_data, w_rx_data_n;
  logic             r_skip, w_skip_n;
  logic             r_tx_ack, w_tx_ack_n;
  logic             r_rx_valid, w_rx_valid_n;
  logic             r_new_transfer, w_new_transfer_n;
  logic             r_transfer_done, w_transfer_done_n;
  logic             r_frame_error, w_frame_error_n;

  logic w_ncs_fall, w_ncs_rise, w_sck_rise, w_sck_fall;
  logic w_sck_lead, w_sck_trail, w_sample, w_shift, w_mosi;

  // SCK chain resets to its idle level so reset release never looks like an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ncs_sync  <= 3'b111;
      r_sck_sync  <= {3{CPOL}};
      r_mosi_sync <= 2'b00;
    end else begin
      r_ncs_sync  <= {r_ncs_sync[1:0], nCS};
      r_sck_sync  <= {r_sck_sync[1:0], SCK};
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
    end
  end

  assign w_ncs_fall  = r_ncs_sync[2] & ~r_ncs_sync[1];
  assign w_ncs_rise  = ~r_ncs_sync[2] & r_ncs_sync[1];
  assign w_sck_rise  = ~r_sck_sync[2] & r_sck_sync[1];
  assign w_sck_fall  = r_sck_sync[2] & ~r_sck_sync[1];
  assign w_sck_lead  = CPOL ? w_sck_fall : w_sck_rise;
  assign w_sck_trail = CPOL ? w_sck_rise : w_sck_fall;
  assign w_sample    = CPHA ? w_sck_trail : w_sck_lead;
  assign w_shift     = CPHA ? w_sck_lead : w_sck_trail;
  assign w_mosi      = r_mosi_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n         = r_state;
    w_bitcnt_n        = r_bitcnt;
    w_txshift_n       = r_txshift;
    w_rxshift_n       = r_rxshift;
    w_rx_data_n       = r_rx_data;
    w_skip_n          = r_skip;
    w_tx_ack_n        = 1'b0;
    w_rx_valid_n      = 1'b0;
    w_new_transfer_n  = 1'b0;
    w_transfer_done_n = 1'b0;
    w_frame_error_n   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_bitcnt_n = '0;
        if (w_ncs_fall) begin
          w_state_n        = S_ACTIVE;
          w_txshift_n      = tx_data;
          w_tx_ack_n       = 1'b1;
          w_skip_n         = CPHA;
          w_new_transfer_n = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (w_sample) begin
          w_rxshift_n = {r_rxshift[width-2:0], w_mosi};
          if (r_bitcnt == LAST_BIT) begin
            // next word is loaded now, so the following shift edge must leave its MSB in place
            w_rx_data_n  = {r_rxshift[width-2:0], w_mosi};
            w_rx_valid_n = 1'b1;
            w_bitcnt_n   = '0;
            w_txshift_n  = tx_data;
            w_tx_ack_n   = 1'b1;
            w_skip_n     = 1'b1;
          end else begin
            w_bitcnt_n = r_bitcnt + CW'(1);
          end
        end else if (w_shift) begin
          if (r_skip) begin
            w_skip_n = 1'b0;
          end else begin
            w_txshift_n = {r_txshift[width-2:0], 1'b0};
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_ncs_rise) begin
      w_state_n         = S_IDLE;
      w_transfer_done_n = 1'b1;
      w_frame_error_n   = (r_bitcnt != '0);
      w_bitcnt_n        = '0;
      w_rx_valid_n      = 1'b0;
      w_rx_data_n       = r_rx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bitcnt        <= '0;
      r_txshift       <= '0;
      r_rxshift       <= '0;
      r_rx_data       <= '0;
      r_skip          <= 1'b0;
      r_tx_ack        <= 1'b0;
      r_rx_valid      <= 1'b0;
      r_new_transfer  <= 1'b0;
      r_transfer_done <= 1'b0;
      r_frame_error   <= 1'b0;
    end else begin
      r_bitcnt        <= w_bitcnt_n;
      r_txshift       <= w_txshift_n;
      r_rxshift       <= w_rxshift_n;
      r_rx_data       <= w_rx_data_n;
      r_skip          <= w_skip_n;
      r_tx_ack        <= w_tx_ack_n;
      r_rx_valid      <= w_rx_valid_n;
      r_new_transfer  <= w_new_transfer_n;
      r_transfer_done <= w_transfer_done_n;
      r_frame_error   <= w_frame_error_n;
    end
  end

  assign MISO          = (r_state == S_ACTIVE) & r_txshift[width-1];
  assign MISO_oe       = (r_state == S_ACTIVE);
  assign busy          = (r_state == S_ACTIVE);
  assign tx_ack        = r_tx_ack;
  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign new_transfer  = r_new_transfer;
  assign transfer_done = r_transfer_done;
  assign frame_error   = r_frame_error;

endmodule

// File: tb/tb_spi_slave_xfer.sv
`timescale 1ns/1ps
// Bench for spi_slave_xfer: four instances (modes 0/3 at 24 bits, modes 1/2 at 8 bits)
// driven by a bit-level SPI master model; received words are checked through a scoreboard queue.
module tb_spi_slave_xfer;

  localparam int H = 80;
  localparam logic [3:0] CPOL_V = 4'b1010;
  localparam logic [3:0] CPHA_V = 4'b0110;

  typedef struct {
    int          inst;
    logic [23:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] ncs, sck, mosi;
  logic [3:0][23:0] txd;
  wire  [3:0] miso, oe, tx_ack, rx_valid, nt, td, fe, busy;
  wire  [3:0][23:0] rxd;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cnt_ack[4] = '{default: 0};
  int cnt_nt[4]  = '{default: 0};
  int cnt_td[4]  = '{default: 0};
  int cnt_fe[4]  = '{default: 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g < 2) ? 24 : 8;
    wire [W-1:0] w_rx;
    spi_slave_xfer #(.width(W), .CPOL(CPOL_V[g]), .CPHA(CPHA_V[g])) u_dut (
      .clk(clk), .reset(reset), .nCS(ncs[g]), .SCK(sck[g]), .MOSI(mosi[g]),
      .MISO(miso[g]), .MISO_oe(oe[g]), .tx_data(txd[g][W-1:0]), .tx_ack(tx_ack[g]),
      .rx_data(w_rx), .rx_valid(rx_valid[g]), .new_transfer(nt[g]),
      .transfer_done(td[g]), .frame_error(fe[g]), .busy(busy[g])
    );
    assign rxd[g] = 24'(w_rx);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (tx_ack[i]) cnt_ack[i]++;
      if (nt[i]) cnt_nt[i]++;
      if (td[i]) cnt_td[i]++;
      if (fe[i]) begin
        cnt_fe[i]++;
        chk("fe_with_done", td[i], 1);
      end
      if (rx_valid[i]) begin
        if (exp_q.size() == 0) begin
          chk("rx_unexpected_q_size", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rx_inst", i, e.inst);
          chk("rx_data", rxd[i], e.val);
        end
      end
    end
  end

  task automatic frame_start(input int i);
    ncs[i] = 1'b0;
    #(H);
  endtask

  task automatic frame_end(input int i);
    #(H);
    ncs[i] = 1'b1;
    #(4*H);
  endtask

  task automatic xfer_bits(input int i, input int nbits, input logic [23:0] val,
                           output logic [23:0] cap);
    cap = '0;
    for (int b = nbits - 1; b >= 0; b--) begin
      if (!CPHA_V[i]) begin
        mosi[i] = val[b];
        #(H);
        cap = {cap[22:0], miso[i]};
        sck[i] = ~CPOL_V[i];
        #(H);
        sck[i] = CPOL_V[i];
      end else begin
        sck[i] = ~CPOL_V[i];
        mosi[i] = val[b];
        #(H);
        cap = {cap[22:0], miso[i]};
        sck[i] = CPOL_V[i];
        #(H);
      end
    end
  endtask

  task automatic word(input int i, input int w, input logic [23:0] val,
                      input logic [23:0] tx_exp, input string tag);
    logic [23:0] cap;
    exp_t e;
    e.inst = i;
    e.val  = val;
    exp_q.push_back(e);
    xfer_bits(i, w, val, cap);
    chk(tag, cap, tx_exp);
  endtask

  int b_ack, b_nt, b_td, b_fe;

  task automatic snap(input int i);
    b_ack = cnt_ack[i];
    b_nt  = cnt_nt[i];
    b_td  = cnt_td[i];
    b_fe  = cnt_fe[i];
  endtask

  initial begin
    logic [23:0] cap;
    reset = 1'b1;
    ncs   = 4'hF;
    sck   = CPOL_V;
    mosi  = 4'h0;
    txd   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_oe", oe, 0);
    chk("rst_miso", miso, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data0", rxd[0], 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // mode 0, single 24-bit word
    txd[0] = 24'h123456;
    snap(0);
    frame_start(0);
    chk("m0_oe_in_frame", oe[0], 1);
    chk("m0_busy_in_frame", busy[0], 1);
    word(0, 24, 24'hA5C3F0, 24'h123456, "m0_miso_word");
    frame_end(0);
    chk("m0_tx_ack_cnt", cnt_ack[0] - b_ack, 2);
    chk("m0_nt_cnt", cnt_nt[0] - b_nt, 1);
    chk("m0_td_cnt", cnt_td[0] - b_td, 1);
    chk("m0_fe_cnt", cnt_fe[0] - b_fe, 0);
    chk("m0_q_empty", exp_q.size(), 0);

    // mode 3, two back-to-back words
    txd[1] = 24'hABCDEF;
    snap(1);
    frame_start(1);
    word(1, 24, 24'h000001, 24'hABCDEF, "m3_miso_word1");
    word(1, 24, 24'hFFFFFE, 24'hABCDEF, "m3_miso_word2");
    frame_end(1);
    chk("m3_nt_cnt", cnt_nt[1] - b_nt, 1);
    chk("m3_td_cnt", cnt_td[1] - b_td, 1);
    chk("m3_fe_cnt", cnt_fe[1] - b_fe, 0);
    chk("m3_q_empty", exp_q.size(), 0);

    // modes 1 and 2, 8-bit words
    for (int i = 2; i < 4; i++) begin
      txd[i] = 24'h00007E;
      chk("m12_oe_before", oe[i], 0);
      frame_start(i);
      chk("m12_oe_in_frame", oe[i], 1);
      word(i, 8, 24'h000081, 24'h00007E, "m12_miso_word");
      frame_end(i);
      chk("m12_oe_after", oe[i], 0);
      chk("m12_miso_after", miso[i], 0);
    end
    chk("m12_q_empty", exp_q.size(), 0);

    // aborted frame after 10 bits, then a clean frame
    txd[0] = 24'h0F0F0F;
    snap(0);
    frame_start(0);
    xfer_bits(0, 10, 24'h0003FF, cap);
    frame_end(0);
    chk("abort_fe_cnt", cnt_fe[0] - b_fe, 1);
    chk("abort_td_cnt", cnt_td[0] - b_td, 1);
    chk("abort_q_empty", exp_q.size(), 0);
    frame_start(0);
    word(0, 24, 24'h5A5A5A, 24'h0F0F0F, "post_abort_miso");
    frame_end(0);
    chk("post_abort_q_empty", exp_q.size(), 0);

    // reset in the middle of a frame
    txd[0] = 24'h654321;
    frame_start(0);
    xfer_bits(0, 12, 24'h000FFF, cap);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_oe", oe[0], 0);
    chk("midrst_miso", miso[0], 0);
    chk("midrst_rx_data", rxd[0], 0);
    chk("midrst_pulses", {tx_ack[0], rx_valid[0], nt[0], td[0], fe[0]}, 0);
    ncs[0] = 1'b1;
    sck[0] = CPOL_V[0];
    snap(0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_nt", cnt_nt[0] - b_nt, 0);
    chk("midrst_no_td", cnt_td[0] - b_td, 0);
    chk("midrst_no_fe", cnt_fe[0] - b_fe, 0);
    chk("midrst_no_ack", cnt_ack[0] - b_ack, 0);
    frame_start(0);
    word(0, 24, 24'h13579B, 24'h654321, "post_rst_miso");
    frame_end(0);

    // SCK activity with nCS high, then a single-clk nCS glitch
    snap(0);
    for (int k = 0; k < 10; k++) begin
      mosi[0] = 1'($urandom_range(0, 1));
      sck[0] = ~sck[0];
      #(H);
    end
    sck[0] = CPOL_V[0];
    #(H);
    chk("idle_sck_bitcnt", g_dut[0].u_dut.r_bitcnt, 0);
    @(negedge clk);
    ncs[0] = 1'b0;
    @(negedge clk);
    ncs[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_nt_cnt", cnt_nt[0] - b_nt, 1);
    chk("glitch_td_cnt", cnt_td[0] - b_td, 1);
    chk("glitch_fe_cnt", cnt_fe[0] - b_fe, 0);
    chk("glitch_bitcnt", g_dut[0].u_dut.r_bitcnt, 0);
    txd[0] = 24'hC0FFEE;
    frame_start(0);
    word(0, 24, 24'h2468AC, 24'hC0FFEE, "post_glitch_miso");
    frame_end(0);

    chk("final_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
